// File: rtl/next_addr_sequencer_if.sv
// Bus between the next-address sequencer and its environment: core control,
// instruction fetch handshake, execute-stage branch/flag inputs, and status.
interface next_addr_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  // core control
  logic              start;
  logic              halt;
  // instruction fetch
  logic              fetchReq;
  logic [ADDR_W-1:0] fetchAddr;
  logic              fetchAck;
  // execute stage
  logic              execValid;
  logic              isBranch;
  logic [2:0]        brType;
  logic [ADDR_W-1:0] brTarget;
  logic              flagWe;
  logic              zIn;
  logic              cIn;
  logic              sIn;
  logic              vIn;
  // status
  logic [ADDR_W-1:0] pc;
  logic              zFlag;
  logic              carryFlag;
  logic              signFlag;
  logic              overflowFlag;
  logic              brTaken;
  logic              busy;
  logic              fetchErr;

  // sequencer side
  modport master (
    input  start, halt, fetchAck, execValid, isBranch, brType, brTarget,
           flagWe, zIn, cIn, sIn, vIn,
    output fetchReq, fetchAddr, pc, zFlag, carryFlag, signFlag, overflowFlag,
           brTaken, busy, fetchErr
  );

  // environment side
  modport slave (
    output start, halt, fetchAck, execValid, isBranch, brType, brTarget,
           flagWe, zIn, cIn, sIn, vIn,
    input  fetchReq, fetchAddr, pc, zFlag, carryFlag, signFlag, overflowFlag,
           brTaken, busy, fetchErr
  );
endinterface

// File: rtl/next_addr_sequencer.sv
// Next-address sequencer: owns the PC and Z/C/S/V flags, runs the fetch
// handshake with a bounded wait, and resolves branches on instruction retire.
module next_addr_sequencer #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned RESET_ADDR    = 0,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  rstN,
  next_addr_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALTED
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              s_q, s_d;
  logic              v_q, v_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              taken_q, taken_d;
  logic              req_q, req_d;
  logic              cond;

  // Branch condition, always on the flags as registered before this edge
  always_comb begin
    cond = 1'b0;
    case (bus.brType)
      3'd0:    cond = z_q;
      3'd1:    cond = c_q;
      3'd2:    cond = s_q;
      3'd3:    cond = v_q;
      3'd4:    cond = ~z_q;
      3'd5:    cond = ~c_q;
      3'd6:    cond = ~s_q;
      default: cond = 1'b1;
    endcase
  end

  // Next-state, PC, flag, timeout and pulse logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    z_d     = z_q;
    c_d     = c_q;
    s_d     = s_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    taken_d = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (bus.start) begin
          state_d = FETCH;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        // the current cycle counts toward the limit, so an ack on the
        // limiting cycle still wins over the timeout
        if (bus.fetchAck) begin
          state_d = EXEC;
          cnt_d   = '0;
        end else if (cnt_q == 8'(FETCH_TIMEOUT - 1)) begin
          state_d = HALTED;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      EXEC: begin
        if (bus.execValid) begin
          if (bus.isBranch && cond) begin
            pc_d    = bus.brTarget;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
          if (bus.flagWe) begin
            z_d = bus.zIn;
            c_d = bus.cIn;
            s_d = bus.sIn;
            v_d = bus.vIn;
          end
          state_d = bus.halt ? HALTED : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == FETCH);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      pc_q    <= ADDR_W'(RESET_ADDR);
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      s_q     <= 1'b0;
      v_q     <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      taken_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      s_q     <= s_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      taken_q <= taken_d;
      req_q   <= req_d;
    end
  end

  assign bus.fetchReq     = req_q;
  assign bus.fetchAddr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.zFlag        = z_q;
  assign bus.carryFlag    = c_q;
  assign bus.signFlag     = s_q;
  assign bus.overflowFlag = v_q;
  assign bus.brTaken      = taken_q;
  assign bus.busy         = (state_q == FETCH) || (state_q == EXEC);
  assign bus.fetchErr     = err_q;

endmodule
